// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider producing one quotient bit per clock
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_shift_q, q_shift_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_next;
   logic             ge;
   // next-state: accept in IDLE/DONE, one restoring step per cycle in CALC
   always_comb begin
      state_d   = state_q;
      q_shift_d = q_shift_q;
      acc_d     = acc_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      acc_next  = {acc_q, q_shift_q[WIDTH-1]};
      ge        = acc_next >= {1'b0, dvs_q};
      case (state_q)
         CALC: begin
            acc_d     = ge ? WIDTH'(acc_next - {1'b0, dvs_q}) : acc_next[WIDTH-1:0];
            q_shift_d = {q_shift_q[WIDTH-2:0], ge};
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               quot_d  = q_shift_d;
               rem_d   = acc_d;
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         default: begin
            if (start && divisor == '0) begin
               quot_d  = '1;
               rem_d   = dividend;
               dbz_d   = 1'b1;
               state_d = DONE;
            end else if (start) begin
               q_shift_d = dividend;
               dvs_d     = divisor;
               acc_d     = '0;
               cnt_d     = '0;
               state_d   = CALC;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end
   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         q_shift_q <= '0;
         acc_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_shift_q <= q_shift_d;
         acc_q     <= acc_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
      end
   end
   assign busy        = state_q == CALC;
   assign done        = state_q == DONE;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model
module tb_seq_divider;
   logic       clk = 1'b0;
   logic       rst, start, busy, done, div_by_zero;
   logic [7:0] dividend, divisor, quotient, remainder;
   int         passed = 0, total = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // called at a negedge; returns at the negedge where done is seen
   task automatic run(input logic [7:0] a, input logic [7:0] b, input bit intr);
      int  cyc, bcnt, eq, er;
      bit  ez;
      ez = (b == 0);
      eq = ez ? 255 : a / b;
      er = ez ? int'(a) : a % b;
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
      cyc = 1; bcnt = 0;
      while (!done && cyc < 20) begin
         if (busy) bcnt++;
         start = intr && cyc == 3;
         if (start) begin dividend = 50; divisor = 5; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, ez ? 1 : 9);
      chk("busy_cycles", bcnt, ez ? 0 : 8);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", div_by_zero, ez);
      if (!ez) begin
         chk("invariant", int'(quotient) * int'(b) + int'(remainder), int'(a));
         chk("rem_lt_div", int'(remainder < b), 1);
      end
   endtask

   initial begin
      int dn;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      run(100, 7, 0);
      @(negedge clk); chk("single_done", done, 0);
      run(255, 1, 0);   @(negedge clk);
      run(3, 10, 0);    @(negedge clk);
      run(255, 255, 0); @(negedge clk);
      run(5, 0, 0);
      @(negedge clk); chk("dbz_single_done", done, 0);
      run(200, 9, 1);
      @(negedge clk); chk("ignored_start_one_done", done, 0);
      chk("ignored_start_busy", busy, 0);
      run(20, 3, 0);
      run(81, 9, 0);
      @(negedge clk);
      start = 1'b1; dividend = 100; divisor = 7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_quotient", quotient, 0);
      chk("async_remainder", remainder, 0);
      chk("async_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (12) begin @(negedge clk); dn += int'(done); end
      chk("abort_no_done", dn, 0);
      run(100, 7, 0);
      @(negedge clk);
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         run(ra, rb, 0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
